// File: rtl/util_pkg.sv
// Shared helpers for the PWM bank: ceiling-log2 for index widths and the
// counter mode/direction encodings.
package util_pkg;

  typedef enum logic {
    EDGE   = 1'b0,
    CENTER = 1'b1
  } pwm_mode;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } count_dir_e;

  // Ceiling log2; CLOG2(1) is 0, so callers clamp port widths to at least 1.
  function automatic int CLOG2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pwm_bank_channel.sv
// One PWM channel: double-buffered duty (shadow/active) with write-at-boundary
// bypass, and a registered compare against the shared counter.
module pwm_bank_channel
  import util_pkg::*;
#(
  parameter int BITS   = 8,
  parameter int CHW    = 2,
  parameter int CH_IDX = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [CHW-1:0]  wr_chan,
  input  logic [BITS-1:0] wr_duty,
  input  logic            boundary,
  input  logic [BITS-1:0] counter,
  output logic            out
);

  logic            wr_hit;
  logic [BITS-1:0] shadow_reg;
  logic [BITS-1:0] shadow_next;
  logic [BITS-1:0] active_reg;
  logic [BITS-1:0] active_next;
  logic            out_reg;

  // Out-of-range indices can never equal a valid CH_IDX, so they are dropped.
  assign wr_hit = wr_en && (wr_chan == CHW'(CH_IDX));

  always_comb begin
    shadow_next = wr_hit ? wr_duty : shadow_reg;
    // Latching from shadow_next lets a boundary-cycle write land immediately.
    active_next = boundary ? shadow_next : active_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_reg <= '0;
      active_reg <= '0;
      out_reg    <= 1'b0;
    end else begin
      shadow_reg <= shadow_next;
      active_reg <= active_next;
      out_reg    <= (counter < active_reg);
    end
  end

  assign out = out_reg;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM with a shared period counter and glitch-free duty updates.
// Define PWM_BANK_CENTER_EN for center-aligned (up/down) counting.
module pwm_bank
  import util_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int BITS     = 8,
  localparam int CHW      = (CLOG2(CHANNELS) > 0) ? CLOG2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BITS-1:0]     period,
  input  logic                wr_en,
  input  logic [CHW-1:0]      wr_chan,
  input  logic [BITS-1:0]     wr_duty,
  output logic [CHANNELS-1:0] out,
  output logic                cycle_strobe
);

  logic [BITS-1:0] counter_reg;
  logic [BITS-1:0] counter_next;
  logic [BITS-1:0] period_act_reg;
  logic            boundary;
  logic            strobe_reg;

`ifdef PWM_BANK_CENTER_EN
  count_dir_e dir_reg;
  count_dir_e dir_next;

  // Up 0..period_act, then down to 1; the period closes at 1 on the way down.
  always_comb begin
    boundary     = 1'b0;
    counter_next = counter_reg;
    dir_next     = dir_reg;
    if (period_act_reg == '0) begin
      boundary = 1'b1;
    end else if (dir_reg == DIR_UP) begin
      if (counter_reg == period_act_reg) begin
        if (period_act_reg == BITS'(1)) begin
          boundary = 1'b1;
        end else begin
          dir_next     = DIR_DOWN;
          counter_next = counter_reg - 1'b1;
        end
      end else begin
        counter_next = counter_reg + 1'b1;
      end
    end else begin
      if (counter_reg == BITS'(1)) begin
        boundary = 1'b1;
      end else begin
        counter_next = counter_reg - 1'b1;
      end
    end
    if (boundary) begin
      counter_next = '0;
      dir_next     = DIR_UP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dir_reg <= DIR_UP;
    end else begin
      dir_reg <= dir_next;
    end
  end
`else
  always_comb begin
    boundary     = (counter_reg == period_act_reg);
    counter_next = boundary ? '0 : counter_reg + 1'b1;
  end
`endif

  // period_act tracks the input during reset so the first period is correct.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter_reg    <= '0;
      period_act_reg <= period;
      strobe_reg     <= 1'b0;
    end else begin
      counter_reg <= counter_next;
      strobe_reg  <= boundary;
      if (boundary) begin
        period_act_reg <= period;
      end
    end
  end

  assign cycle_strobe = strobe_reg;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    pwm_bank_channel #(
      .BITS   (BITS),
      .CHW    (CHW),
      .CH_IDX (gi)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_chan  (wr_chan),
      .wr_duty  (wr_duty),
      .boundary (boundary),
      .counter  (counter_reg),
      .out      (out[gi])
    );
  end

endmodule
